modulation_az_seq: RTL and testbench
====================================

Name: modulation_az_seq

Overview:
Parametrised successor to the single-channel AZ modulator. Sequences the precharge switch and AZ mux over up to NSLOT hi inputs, each optionally followed by a LO (zero) sample. Mode-selectable: off, hi-only (no-AZ), or interleaved AZ. Runtime-programmable precharge and sample durations, with a run/stop control and per-sample completion strobe. Sits between the register bank and the analog mux/ADC-integration control.

Parameters:
MUX_W, 4, azmux code width
CNT_W, 32, sample-duration counter width
PC_W, 24, precharge-duration counter width
NSLOT, 4, max hi slots per cycle (1..16)
IDX_W, 4, slot index width (covers NSLOT-1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low; asserted when 0
run  in  1  level; 1 = sequence, 0 = finish current slot then idle
mode  in  2  0 off, 1 hi-only, 2 AZ (hi then lo per slot), 3 reserved = off
slot_count  in  IDX_W+1  active slots, 1..NSLOT; 0 treated as 1, >NSLOT clamped to NSLOT
azmux_hi_vals  in  NSLOT*MUX_W  hi code per slot, slot i at [i*MUX_W +: MUX_W]
azmux_lo_val  in  MUX_W  lo code
clk_precharge_duration  in  PC_W  precharge/settle/protect phase length, clocks
clk_sample_duration  in  CNT_W  sample window length, clocks
sw_pc_ctl  out  1  1 = SIGNAL, 0 = BOOT
azmux  out  MUX_W  AZ mux code
sample_active  out  1  high throughout any sample window
sample_done  out  1  one-cycle pulse, last cycle of a sample window
sample_idx  out  IDX_W  slot of current/just-finished sample
sample_is_lo  out  1  current/just-finished sample is a lo sample
busy  out  1  high whenever state != IDLE
led0  out  1  high during hi sample windows
monitor  out  8  [0] azmux on hi, [1] pc SIGNAL, [2] sample_done, [3] lo sample, [7:4] slot idx

Behaviour:
- Reset (async, reset==0): state IDLE; sw_pc_ctl=BOOT(0), azmux=0, all other outputs 0. Exit synchronous on first clk edge with reset==1.
- Config snapshot: mode, slot_count, durations, mux codes latched on IDLE exit and again on every wrap to slot 0. Mid-cycle input changes have no effect until the next wrap.
- Phase timing: outputs change on the first clk edge of a phase; the next change occurs exactly max(N,1) cycles later, where N is the phase's duration (zero duration = 1 cycle).
- States:
  - IDLE: pc=BOOT, azmux=0. Go to PC_BOOT when run=1 and mode in {1,2}.
  - PC_BOOT: pc=BOOT, precharge length; entered once per run start.
  - SETTLE: azmux=hi[slot], pc=BOOT, precharge length.
  - HI_SAMPLE: pc=SIGNAL, led0=1, sample length.
  - PROTECT: pc=BOOT, precharge length. Then LO_SAMPLE if mode=2, else NEXT.
  - LO_SAMPLE: azmux=lo, led0=0, sample length.
  - NEXT: 0 cycles (combinational decision). slot+1, wrapping to 0 after slot_count-1 with config re-snapshot. If run=0 or snapshot mode is off, go to IDLE; else go to SETTLE.
- sample_done pulses on the final cycle of HI_SAMPLE/LO_SAMPLE, with sample_idx and sample_is_lo valid that cycle.
- run deassert mid-slot: the slot completes, including its lo sample in AZ mode; stops at NEXT. pc is always BOOT before azmux changes.
- Simultaneous run fall and wrap: go to IDLE; no re-snapshot side effects visible.
- No azmux change ever coincides with pc=SIGNAL.

Decomposition:
- Shared package: SW_PC_SIGNAL/SW_PC_BOOT constants, mode codes, state encoding, monitor bit indices.
- Sub-module phase_timer: CNT_W down-counter with load value, zero-clamp to 1, and done flag. One instance, loaded with the precharge or sample duration (precharge zero-extended).

Test Plan:
- Reset mid-HI_SAMPLE: drive reset=0 -> sw_pc_ctl=0, azmux=0, busy=0 immediately, without a clock edge.
- AZ, slot_count=2, PC=3, S=5, hi={1000,0100}, lo=0001, run=1 -> PC_BOOT 3 cycles, then a 16-cycle period per slot with hi 1000/lo/hi 0100/lo; sample_done every 8/8 cycles alternating is_lo; sample_idx 0,0,1,1.
- Hi-only mode, slot_count=3, PC=2, S=4 -> no lo code ever appears; 8-cycle slot period; sample_is_lo always 0; idx cycles 0,1,2,0.
- Durations 0/0 -> every phase 1 cycle; AZ slot period 4 cycles; no hang.
- run falls during SETTLE of slot 1 (AZ) -> slot 1 hi and lo samples complete, then IDLE with pc=BOOT, azmux=0; exactly 2 further sample_done pulses.
- Change slot_count 2->4 mid-cycle -> takes effect only after the slot 1 -> 0 wrap; slot_count=0 behaves as 1; slot_count=9 with NSLOT=4 clamps to 4.

Source files
------------

// File: rtl/modulation_az_seq_pkg.sv
// Shared constants and types for the AZ sequencer: precharge switch levels,
// mode codes, FSM state encoding and monitor bus bit positions.
package modulation_az_seq_pkg;

  localparam logic SW_PC_SIGNAL = 1'b1;
  localparam logic SW_PC_BOOT   = 1'b0;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_HI_ONLY = 2'd1;
  localparam logic [1:0] MODE_AZ      = 2'd2;
  localparam logic [1:0] MODE_RSVD    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PC_BOOT,
    ST_SETTLE,
    ST_HI_SAMPLE,
    ST_PROTECT,
    ST_LO_SAMPLE
  } state_t;

  localparam int MON_AZ_HI     = 0;
  localparam int MON_PC_SIGNAL = 1;
  localparam int MON_DONE      = 2;
  localparam int MON_LO        = 3;
  localparam int MON_IDX_LSB   = 4;

  // Reserved mode 3 behaves exactly like off.
  function automatic logic mode_active(input logic [1:0] m);
    return (m == MODE_HI_ONLY) || (m == MODE_AZ);
  endfunction

endpackage

// File: rtl/modulation_az_seq_phase_timer.sv
// Phase length down-counter: loaded on each phase entry, flags the last cycle
// of the phase. A zero load value is treated as a one-cycle phase.
module modulation_az_seq_phase_timer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= (i_load_val == '0) ? CNT_W'(1) : i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/modulation_az_seq.sv
// Multi-slot auto-zero sequencer: drives the precharge switch and AZ mux
// through hi (and optional lo) samples for each active slot.
module modulation_az_seq
  import modulation_az_seq_pkg::*;
#(
  parameter int MUX_W = 4,
  parameter int CNT_W = 32,
  parameter int PC_W  = 24,
  parameter int NSLOT = 4,
  parameter int IDX_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   run,
  input  logic [1:0]             mode,
  input  logic [IDX_W:0]         slot_count,
  input  logic [NSLOT*MUX_W-1:0] azmux_hi_vals,
  input  logic [MUX_W-1:0]       azmux_lo_val,
  input  logic [PC_W-1:0]        clk_precharge_duration,
  input  logic [CNT_W-1:0]       clk_sample_duration,
  output logic                   sw_pc_ctl,
  output logic [MUX_W-1:0]       azmux,
  output logic                   sample_active,
  output logic                   sample_done,
  output logic [IDX_W-1:0]       sample_idx,
  output logic                   sample_is_lo,
  output logic                   busy,
  output logic                   led0,
  output logic [7:0]             monitor
);

  localparam logic [IDX_W:0] NSLOT_V = (IDX_W+1)'(NSLOT);

  // Index of the last active slot; 0 acts as 1 slot, oversize clamps to NSLOT.
  function automatic logic [IDX_W-1:0] last_slot(input logic [IDX_W:0] cnt);
    if (cnt == '0)          return '0;
    else if (cnt > NSLOT_V) return IDX_W'(NSLOT - 1);
    else                    return IDX_W'(cnt - (IDX_W+1)'(1));
  endfunction

  state_t                 r_state;
  logic [IDX_W-1:0]       r_slot;
  logic [1:0]             r_mode;
  logic [IDX_W-1:0]       r_last_slot;
  logic [PC_W-1:0]        r_pc_dur;
  logic [CNT_W-1:0]       r_s_dur;
  logic [NSLOT*MUX_W-1:0] r_hi_vals;
  logic [MUX_W-1:0]       r_lo_val;

  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_slot_nxt;
  logic             w_snap;
  logic             w_next;
  logic             w_wrap;
  logic             w_done;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic [PC_W-1:0]  w_pc_src;
  logic [CNT_W-1:0] w_s_src;
  logic [MUX_W-1:0] w_hi_code;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_slot      <= '0;
      r_mode      <= MODE_OFF;
      r_last_slot <= '0;
      r_pc_dur    <= '0;
      r_s_dur     <= '0;
      r_hi_vals   <= '0;
      r_lo_val    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      if (w_snap) begin
        r_mode      <= mode;
        r_last_slot <= last_slot(slot_count);
        r_pc_dur    <= clk_precharge_duration;
        r_s_dur     <= clk_sample_duration;
        r_hi_vals   <= azmux_hi_vals;
        r_lo_val    <= azmux_lo_val;
      end
    end
  end

  assign w_wrap = (r_slot == r_last_slot);

  // NEXT is folded into the PROTECT/LO exits; a wrap decides on the fresh config.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches are inferred.
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_snap      = 1'b0;
    w_next      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run && mode_active(mode)) begin
          w_state_nxt = ST_PC_BOOT;
          w_slot_nxt  = '0;
          w_snap      = 1'b1;
        end
      end
      ST_PC_BOOT:   if (w_done) w_state_nxt = ST_SETTLE;
      ST_SETTLE:    if (w_done) w_state_nxt = ST_HI_SAMPLE;
      ST_HI_SAMPLE: if (w_done) w_state_nxt = ST_PROTECT;
      ST_PROTECT: begin
        if (w_done) begin
          if (r_mode == MODE_AZ) w_state_nxt = ST_LO_SAMPLE;
          else                   w_next      = 1'b1;
        end
      end
      ST_LO_SAMPLE: if (w_done) w_next = 1'b1;
      default:      w_state_nxt = ST_IDLE;
    endcase

    if (w_next) begin
      if (!run || !mode_active(w_wrap ? mode : r_mode)) begin
        w_state_nxt = ST_IDLE;
      end else begin
        w_state_nxt = ST_SETTLE;
        if (w_wrap) begin
          w_slot_nxt = '0;
          w_snap     = 1'b1;
        end else begin
          w_slot_nxt = r_slot + IDX_W'(1);
        end
      end
    end
  end

  // Durations loaded at a snapshot edge come straight from the inputs being latched.
  assign w_pc_src   = w_snap ? clk_precharge_duration : r_pc_dur;
  assign w_s_src    = w_snap ? clk_sample_duration    : r_s_dur;
  assign w_load     = (w_state_nxt != r_state) && (w_state_nxt != ST_IDLE);
  assign w_load_val = ((w_state_nxt == ST_HI_SAMPLE) || (w_state_nxt == ST_LO_SAMPLE))
                      ? w_s_src : CNT_W'(w_pc_src);

  modulation_az_seq_phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  assign w_hi_code = r_hi_vals[r_slot*MUX_W +: MUX_W];

  // The hi code is held through PROTECT so azmux only moves while pc is BOOT.
  always_comb begin
    sw_pc_ctl     = SW_PC_BOOT;
    azmux         = '0;
    sample_active = 1'b0;
    sample_is_lo  = 1'b0;
    led0          = 1'b0;
    case (r_state)
      ST_SETTLE, ST_PROTECT: azmux = w_hi_code;
      ST_HI_SAMPLE: begin
        sw_pc_ctl     = SW_PC_SIGNAL;
        azmux         = w_hi_code;
        sample_active = 1'b1;
        led0          = 1'b1;
      end
      ST_LO_SAMPLE: begin
        azmux         = r_lo_val;
        sample_active = 1'b1;
        sample_is_lo  = 1'b1;
      end
      default: ;
    endcase
    sample_done = sample_active && w_done;
  end

  assign sample_idx = r_slot;
  assign busy       = (r_state != ST_IDLE);

  always_comb begin
    monitor                    = '0;
    monitor[MON_AZ_HI]         = (r_state == ST_SETTLE) || (r_state == ST_HI_SAMPLE) ||
                                 (r_state == ST_PROTECT);
    monitor[MON_PC_SIGNAL]     = sw_pc_ctl;
    monitor[MON_DONE]          = sample_done;
    monitor[MON_LO]            = sample_is_lo;
    monitor[MON_IDX_LSB +: 4]  = 4'(r_slot);
  end

endmodule

// File: tb/tb_modulation_az_seq.sv
// Scoreboard bench for modulation_az_seq: directed runs push expected sample
// completions; a negedge monitor pops and compares them as they appear.
module tb_modulation_az_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [1:0]  mode;
  logic [4:0]  slot_count;
  logic [15:0] azmux_hi_vals;
  logic [3:0]  azmux_lo_val;
  logic [23:0] clk_precharge_duration;
  logic [31:0] clk_sample_duration;
  logic        sw_pc_ctl;
  logic [3:0]  azmux;
  logic        sample_active;
  logic        sample_done;
  logic [3:0]  sample_idx;
  logic        sample_is_lo;
  logic        busy;
  logic        led0;
  logic [7:0]  monitor;

  modulation_az_seq dut (
    .clk                    (clk),
    .reset                  (reset),
    .run                    (run),
    .mode                   (mode),
    .slot_count             (slot_count),
    .azmux_hi_vals          (azmux_hi_vals),
    .azmux_lo_val           (azmux_lo_val),
    .clk_precharge_duration (clk_precharge_duration),
    .clk_sample_duration    (clk_sample_duration),
    .sw_pc_ctl              (sw_pc_ctl),
    .azmux                  (azmux),
    .sample_active          (sample_active),
    .sample_done            (sample_done),
    .sample_idx             (sample_idx),
    .sample_is_lo           (sample_is_lo),
    .busy                   (busy),
    .led0                   (led0),
    .monitor                (monitor)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int         idx;
    bit         lo;
    logic [3:0] az;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  task automatic push(input int idx, input bit lo, input logic [3:0] az, input int c);
    exp_t e;
    e.idx = idx; e.lo = lo; e.az = az; e.cyc = c;
    exp_q.push_back(e);
  endtask

  // Monitor: scoreboard pop on sample_done plus the pc-before-azmux invariant.
  logic [3:0] prev_az   = '0;
  logic       prev_pc   = 1'b0;
  logic       prev_rst  = 1'b0;
  bit         seen_f    = 1'b0;

  always @(negedge clk) begin
    if (reset && prev_rst) begin
      if (azmux !== prev_az)
        check("azmux_moves_with_pc_boot", {62'd0, prev_pc, sw_pc_ctl}, 64'd0);
      if (azmux == 4'hF) seen_f = 1'b1;
      if (sample_done) begin
        check("done_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(e.cyc));
          check("done_idx", 64'(sample_idx), 64'(e.idx));
          check("done_is_lo", 64'(sample_is_lo), 64'(e.lo));
          check("done_azmux", 64'(azmux), 64'(e.az));
          check("done_led0", 64'(led0), 64'(!e.lo));
        end
      end
    end
    prev_az  = azmux;
    prev_pc  = sw_pc_ctl;
    prev_rst = reset;
  end

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic configure(input logic [1:0] m, input logic [4:0] sc, input logic [15:0] hi,
                           input logic [3:0] lo, input int pc, input int s);
    mode                   = m;
    slot_count             = sc;
    azmux_hi_vals          = hi;
    azmux_lo_val           = lo;
    clk_precharge_duration = 24'(pc);
    clk_sample_duration    = 32'(s);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_pc"}, 64'(sw_pc_ctl), 64'd0);
    check({tag, "_azmux"}, 64'(azmux), 64'd0);
    check({tag, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b0;
    run   = 1'b0;
    configure(2'd0, 5'd1, 16'h0, 4'h0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", 64'(sw_pc_ctl), 64'd0);
    check("rst_azmux", 64'(azmux), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_monitor", 64'(monitor), 64'd0);
    check("rst_sample_active", 64'(sample_active), 64'd0);
    reset = 1'b1;

    // Reserved mode 3 must not start a sequence.
    configure(2'd3, 5'd1, 16'h0001, 4'h1, 1, 1);
    k = cyc; run = 1'b1;
    wait_to(k + 4);
    check("mode3_busy", 64'(busy), 64'd0);
    run = 1'b0;
    wait_to(k + 5);

    // AZ, 2 slots, PC=3, S=5; run falls in SETTLE of slot 1.
    configure(2'd2, 5'd2, 16'h0048, 4'h1, 3, 5);
    k = cyc; run = 1'b1;
    push(0, 1'b0, 4'h8, k + 11);
    push(0, 1'b1, 4'h1, k + 19);
    push(1, 1'b0, 4'h4, k + 27);
    push(1, 1'b1, 4'h1, k + 35);
    wait_to(k + 1);
    check("az_pcboot_busy", 64'(busy), 64'd1);
    check("az_pcboot_az", 64'(azmux), 64'd0);
    wait_to(k + 4);
    check("az_settle0_az", 64'(azmux), 64'h8);
    check("az_settle0_pc", 64'(sw_pc_ctl), 64'd0);
    wait_to(k + 7);
    check("az_hi0_pc", 64'(sw_pc_ctl), 64'd1);
    check("az_hi0_monitor", 64'(monitor), 64'h03);
    wait_to(k + 11);
    check("az_hi0_done_monitor", 64'(monitor), 64'h07);
    wait_to(k + 19);
    check("az_lo0_done_monitor", 64'(monitor), 64'h0C);
    wait_to(k + 20);
    check("az_settle1_az", 64'(azmux), 64'h4);
    run = 1'b0;
    wait_to(k + 27);
    check("az_hi1_done_monitor", 64'(monitor), 64'h17);
    wait_to(k + 35);
    check("az_last_lo_busy", 64'(busy), 64'd1);
    wait_to(k + 36);
    check_idle("az_stop");

    // Hi-only, 3 slots, PC=2, S=4: 8-cycle slot period, lo code never driven.
    seen_f = 1'b0;
    configure(2'd1, 5'd3, 16'h0653, 4'hF, 2, 4);
    k = cyc; run = 1'b1;
    push(0, 1'b0, 4'h3, k + 8);
    push(1, 1'b0, 4'h5, k + 16);
    push(2, 1'b0, 4'h6, k + 24);
    push(0, 1'b0, 4'h3, k + 32);
    wait_to(k + 28);
    run = 1'b0;
    wait_to(k + 35);
    check_idle("hionly_stop");
    check("hionly_no_lo_code", 64'(seen_f), 64'd0);

    // Zero durations, AZ, slot_count=0 acts as one slot: 4-cycle period.
    configure(2'd2, 5'd0, 16'h000A, 4'h5, 0, 0);
    k = cyc; run = 1'b1;
    push(0, 1'b0, 4'hA, k + 3);
    push(0, 1'b1, 4'h5, k + 5);
    push(0, 1'b0, 4'hA, k + 7);
    push(0, 1'b1, 4'h5, k + 9);
    push(0, 1'b0, 4'hA, k + 11);
    push(0, 1'b1, 4'h5, k + 13);
    wait_to(k + 10);
    run = 1'b0;
    wait_to(k + 14);
    check_idle("zero_dur_stop");

    // Hi-only PC=1 S=1: slot_count 2->9 and slot1 code change mid-cycle apply after wrap; 9 clamps to 4.
    configure(2'd1, 5'd2, 16'h8421, 4'h0, 1, 1);
    k = cyc; run = 1'b1;
    push(0, 1'b0, 4'h1, k + 3);
    push(1, 1'b0, 4'h2, k + 6);
    push(0, 1'b0, 4'h1, k + 9);
    push(1, 1'b0, 4'hE, k + 12);
    push(2, 1'b0, 4'h4, k + 15);
    push(3, 1'b0, 4'h8, k + 18);
    push(0, 1'b0, 4'h1, k + 21);
    wait_to(k + 2);
    slot_count    = 5'd9;
    azmux_hi_vals = 16'h84E1;
    wait_to(k + 20);
    run = 1'b0;
    wait_to(k + 23);
    check_idle("clamp_stop");

    // Async reset during HI_SAMPLE clears outputs without a clock edge.
    configure(2'd2, 5'd1, 16'h0007, 4'h2, 3, 5);
    k = cyc; run = 1'b1;
    wait_to(k + 8);
    check("pre_rst_pc_signal", 64'(sw_pc_ctl), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_pc", 64'(sw_pc_ctl), 64'd0);
    check("async_rst_azmux", 64'(azmux), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    run   = 1'b0;
    reset = 1'b1;
    wait_to(cyc + 3);
    check_idle("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
